// File: rtl/controlador_exploracao.sv
// controlador_exploracao
// Sequences one frontier search per novaPosicao request. The request flows
// through these steps:
//   1. Clear the search engine.
//   2. Start the engine with the free sectors enabled.
//   3. Wait for the engine, bounded by a timeout.
//   4. If the first attempt times out, retry once with every sector enabled.
//   5. Hand the destination to navigation with a valid/ready handshake.
//
// Ports
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   novaPosicao           : request pulse; posicaoX/Y and setorBloqueado sampled with it
//   buscaReset            : one-cycle clear pulse to the engine
//   buscaNovoDado         : one-cycle start pulse to the engine
//   buscaEnable           : sector enables to the engine
//   buscaFinalizada       : engine done level
//   buscaDestinoX/Y       : engine result
//   destinoValido/Aceito  : valid/ready toward navigation
//   destinoX/Y            : delivered destination
//   erroTimeout           : sticky flag, both attempts timed out
//   exploracaoCompleta    : sticky flag, engine returned the robot's own cell
//   ocupado               : high whenever the controller is not idle
//
// Optional feature
//   Define CONTROLADOR_EXPLORACAO_ESTATISTICAS_EN to add the saturating
//   counters contadorSucessos and contadorTimeouts.
module controlador_exploracao #(
  parameter int unsigned tamanhoDistancia = 8,
  parameter int unsigned TimeoutCiclos    = 4096
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        novaPosicao,
  input  logic [tamanhoDistancia-1:0] posicaoX,
  input  logic [tamanhoDistancia-1:0] posicaoY,
  input  logic [3:0]                  setorBloqueado,
  output logic                        buscaReset,
  output logic                        buscaNovoDado,
  output logic [3:0]                  buscaEnable,
  input  logic                        buscaFinalizada,
  input  logic [tamanhoDistancia-1:0] buscaDestinoX,
  input  logic [tamanhoDistancia-1:0] buscaDestinoY,
  output logic                        destinoValido,
  input  logic                        destinoAceito,
  output logic [tamanhoDistancia-1:0] destinoX,
  output logic [tamanhoDistancia-1:0] destinoY,
  output logic                        erroTimeout,
  output logic                        exploracaoCompleta,
  output logic                        ocupado
`ifdef CONTROLADOR_EXPLORACAO_ESTATISTICAS_EN
  ,
  output logic [15:0]                 contadorSucessos,
  output logic [15:0]                 contadorTimeouts
`endif
);

  localparam int unsigned larguraContador = $clog2(TimeoutCiclos) + 1;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LIMPA   = 3'd1;
  localparam logic [2:0] DISPARO = 3'd2;
  localparam logic [2:0] AGUARDA = 3'd3;
  localparam logic [2:0] ENTREGA = 3'd4;

  logic [2:0]                  estado;
  logic [2:0]                  estadoProximo;
  logic                        retentativaUsada;
  logic                        retentativaProxima;
  logic [larguraContador-1:0]  contador;
  logic [larguraContador-1:0]  contadorProximo;
  logic [tamanhoDistancia-1:0] posX;
  logic [tamanhoDistancia-1:0] posY;
  logic [tamanhoDistancia-1:0] posXProxima;
  logic [tamanhoDistancia-1:0] posYProxima;
  logic [3:0]                  mascara;
  logic [3:0]                  mascaraProxima;

  logic                        buscaResetProximo;
  logic                        buscaNovoDadoProximo;
  logic [3:0]                  buscaEnableProximo;
  logic [tamanhoDistancia-1:0] destinoXProximo;
  logic [tamanhoDistancia-1:0] destinoYProximo;
  logic                        erroTimeoutProximo;
  logic                        exploracaoCompletaProxima;

  logic                        timeoutAtingido;
  logic                        destinoIgualPosicao;

  // Last allowed waiting cycle of the current attempt.
  assign timeoutAtingido     = (contador == larguraContador'(TimeoutCiclos - 1));
  // Engine pointing back at the robot's own cell means nothing is left to explore.
  assign destinoIgualPosicao = (buscaDestinoX == posX) && (buscaDestinoY == posY);

  // Next-state and next-output logic.
  always_comb begin
    estadoProximo             = estado;
    retentativaProxima        = retentativaUsada;
    contadorProximo           = contador;
    posXProxima               = posX;
    posYProxima               = posY;
    mascaraProxima            = mascara;
    buscaEnableProximo        = buscaEnable;
    destinoXProximo           = destinoX;
    destinoYProximo           = destinoY;
    erroTimeoutProximo        = erroTimeout;
    exploracaoCompletaProxima = exploracaoCompleta;

    case (estado)
      IDLE: begin
        if (novaPosicao) begin
          posXProxima               = posicaoX;
          posYProxima               = posicaoY;
          mascaraProxima            = setorBloqueado;
          // A fully blocked mask makes the first attempt pointless.
          retentativaProxima        = &setorBloqueado;
          erroTimeoutProximo        = 1'b0;
          exploracaoCompletaProxima = 1'b0;
          estadoProximo             = LIMPA;
        end
      end

      LIMPA: begin
        // Enables take effect together with the start pulse.
        buscaEnableProximo = retentativaUsada ? 4'b1111 : ~mascara;
        estadoProximo      = DISPARO;
      end

      DISPARO: begin
        contadorProximo = '0;
        estadoProximo   = AGUARDA;
      end

      AGUARDA: begin
        // A result in the timeout cycle still counts as success.
        if (buscaFinalizada) begin
          destinoXProximo = buscaDestinoX;
          destinoYProximo = buscaDestinoY;
          if (destinoIgualPosicao) begin
            exploracaoCompletaProxima = 1'b1;
            estadoProximo             = IDLE;
          end else begin
            estadoProximo = ENTREGA;
          end
        end else if (timeoutAtingido) begin
          if (!retentativaUsada) begin
            retentativaProxima = 1'b1;
            estadoProximo      = LIMPA;
          end else begin
            erroTimeoutProximo = 1'b1;
            estadoProximo      = IDLE;
          end
        end else begin
          // Never wraps: the timeout fires before the counter tops out.
          contadorProximo = contador + larguraContador'(1);
        end
      end

      ENTREGA: begin
        if (destinoAceito) begin
          estadoProximo = IDLE;
        end
      end

      default: begin
        estadoProximo = IDLE;
      end
    endcase

    // Enables are only meaningful while an attempt is live.
    if ((estadoProximo == IDLE) || (estadoProximo == LIMPA)) begin
      buscaEnableProximo = 4'b0000;
    end

    buscaResetProximo    = (estadoProximo == LIMPA);
    buscaNovoDadoProximo = (estadoProximo == DISPARO);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado             <= IDLE;
      retentativaUsada   <= 1'b0;
      contador           <= '0;
      posX               <= '0;
      posY               <= '0;
      mascara            <= '0;
      buscaReset         <= 1'b0;
      buscaNovoDado      <= 1'b0;
      buscaEnable        <= 4'b0000;
      destinoValido      <= 1'b0;
      destinoX           <= '0;
      destinoY           <= '0;
      erroTimeout        <= 1'b0;
      exploracaoCompleta <= 1'b0;
      ocupado            <= 1'b0;
    end else begin
      estado             <= estadoProximo;
      retentativaUsada   <= retentativaProxima;
      contador           <= contadorProximo;
      posX               <= posXProxima;
      posY               <= posYProxima;
      mascara            <= mascaraProxima;
      buscaReset         <= buscaResetProximo;
      buscaNovoDado      <= buscaNovoDadoProximo;
      buscaEnable        <= buscaEnableProximo;
      destinoValido      <= (estadoProximo == ENTREGA);
      destinoX           <= destinoXProximo;
      destinoY           <= destinoYProximo;
      erroTimeout        <= erroTimeoutProximo;
      exploracaoCompleta <= exploracaoCompletaProxima;
      ocupado            <= (estadoProximo != IDLE);
    end
  end

`ifdef CONTROLADOR_EXPLORACAO_ESTATISTICAS_EN
  logic eventoSucesso;
  logic eventoTimeout;

  assign eventoSucesso = destinoValido && destinoAceito;
  assign eventoTimeout = (estado == AGUARDA) && !buscaFinalizada &&
                         timeoutAtingido && retentativaUsada;

  // Saturating handshake and timeout counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      contadorSucessos <= 16'h0000;
      contadorTimeouts <= 16'h0000;
    end else begin
      if (eventoSucesso && (contadorSucessos != 16'hFFFF)) begin
        contadorSucessos <= contadorSucessos + 16'd1;
      end
      if (eventoTimeout && (contadorTimeouts != 16'hFFFF)) begin
        contadorTimeouts <= contadorTimeouts + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_controlador_exploracao.sv
// Randomized self-checking bench for controlador_exploracao.
// Each request is expanded into a cycle-by-cycle timeline that holds the
// stimulus and the outputs expected after that edge. The timeline is built
// from the protocol rules: attempt length, timeout, retry, handshake, and reset.
module tb_controlador_exploracao;

  localparam int T = 16;

  typedef struct {
    logic       rst, nova, fin, aceito;
    logic [7:0] px, py, bdx, bdy;
    logic [3:0] mask;
    logic       eRst, eNd, eValid, eErro, eCompl, eOcup;
    logic [3:0] eEn;
    logic [7:0] eDx, eDy;
  } linhaT;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       novaPosicao = 1'b0;
  logic [7:0] posicaoX = 8'd0, posicaoY = 8'd0;
  logic [3:0] setorBloqueado = 4'd0;
  logic       buscaReset, buscaNovoDado;
  logic [3:0] buscaEnable;
  logic       buscaFinalizada = 1'b0;
  logic [7:0] buscaDestinoX = 8'd0, buscaDestinoY = 8'd0;
  logic       destinoValido;
  logic       destinoAceito = 1'b0;
  logic [7:0] destinoX, destinoY;
  logic       erroTimeout, exploracaoCompleta, ocupado;

  int erros = 0;
  int checks = 0;

  linhaT linhas[$];
  linhaT esp;
  bit    espValido = 1'b0;

  // Sticky model state carried between transactions.
  logic [7:0] mDx = 8'd0, mDy = 8'd0;
  logic       mErro = 1'b0, mCompl = 1'b0;

  controlador_exploracao #(.tamanhoDistancia(8), .TimeoutCiclos(T)) dut (
    .clock(clock), .reset(reset), .novaPosicao(novaPosicao),
    .posicaoX(posicaoX), .posicaoY(posicaoY), .setorBloqueado(setorBloqueado),
    .buscaReset(buscaReset), .buscaNovoDado(buscaNovoDado), .buscaEnable(buscaEnable),
    .buscaFinalizada(buscaFinalizada), .buscaDestinoX(buscaDestinoX),
    .buscaDestinoY(buscaDestinoY), .destinoValido(destinoValido),
    .destinoAceito(destinoAceito), .destinoX(destinoX), .destinoY(destinoY),
    .erroTimeout(erroTimeout), .exploracaoCompleta(exploracaoCompleta),
    .ocupado(ocupado)
  );

  always #5 clock = ~clock;

  task automatic checar(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      erros++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  // Idle-looking row with random don't-care inputs and the sticky expectations.
  function automatic linhaT base();
    linhaT l;
    l.rst = 1'b0; l.nova = 1'b0; l.fin = 1'b0;
    l.aceito = 1'($urandom);
    l.px = 8'($urandom); l.py = 8'($urandom);
    l.bdx = 8'($urandom); l.bdy = 8'($urandom);
    l.mask = 4'($urandom);
    l.eRst = 1'b0; l.eNd = 1'b0; l.eValid = 1'b0; l.eOcup = 1'b0;
    l.eEn = 4'b0000;
    l.eErro = mErro; l.eCompl = mCompl; l.eDx = mDx; l.eDy = mDy;
    return l;
  endfunction

  // Row while busy: stray requests must be ignored.
  function automatic linhaT ocupadaL();
    linhaT l;
    l = base();
    l.nova = ($urandom % 4 == 0);
    return l;
  endfunction

  task automatic gerar(input logic [7:0] pX, input logic [7:0] pY, input logic [3:0] m,
                       input logic [7:0] rx, input logic [7:0] ry,
                       input int d1, input int d2, input int aceite,
                       input int resetEm, input int gap);
    linhaT l;
    bit retry, fim;
    logic [3:0] en;
    int d;
    mErro = 1'b0; mCompl = 1'b0;
    l = base();
    l.nova = 1'b1; l.px = pX; l.py = pY; l.mask = m;
    l.eRst = 1'b1; l.eOcup = 1'b1;
    linhas.push_back(l);
    retry = (m == 4'b1111);
    fim = 1'b0;
    while (!fim) begin
      en = retry ? 4'b1111 : ~m;
      l = ocupadaL(); l.eNd = 1'b1; l.eEn = en; l.eOcup = 1'b1;
      linhas.push_back(l);
      l = ocupadaL(); l.eEn = en; l.eOcup = 1'b1;
      linhas.push_back(l);
      d = retry ? d2 : d1;
      for (int i = 0; i < T; i++) begin
        l = ocupadaL();
        if (!retry && i == resetEm) begin
          mDx = 8'd0; mDy = 8'd0; mErro = 1'b0; mCompl = 1'b0;
          l = base(); l.rst = 1'b1; l.nova = 1'($urandom);
          linhas.push_back(l);
          fim = 1'b1;
          break;
        end
        if (i == d) begin
          l.fin = 1'b1; l.bdx = rx; l.bdy = ry;
          mDx = rx; mDy = ry; l.eDx = rx; l.eDy = ry;
          if (rx == pX && ry == pY) begin
            mCompl = 1'b1; l.eCompl = 1'b1;
            linhas.push_back(l);
          end else begin
            l.eValid = 1'b1; l.eEn = en; l.eOcup = 1'b1;
            linhas.push_back(l);
            for (int j = 0; j <= aceite; j++) begin
              l = ocupadaL();
              l.aceito = (j == aceite);
              if (j != aceite) begin
                l.eValid = 1'b1; l.eEn = en; l.eOcup = 1'b1;
              end
              linhas.push_back(l);
            end
          end
          fim = 1'b1;
          break;
        end else if (i == T - 1) begin
          if (!retry) begin
            retry = 1'b1;
            l.eRst = 1'b1; l.eOcup = 1'b1;
            linhas.push_back(l);
          end else begin
            mErro = 1'b1; l.eErro = 1'b1;
            linhas.push_back(l);
            fim = 1'b1;
          end
          break;
        end else begin
          l.eEn = en; l.eOcup = 1'b1;
          linhas.push_back(l);
        end
      end
    end
    for (int g = 0; g < gap; g++) linhas.push_back(base());
  endtask

  task automatic tocar();
    linhaT l;
    while (linhas.size() > 0) begin
      l = linhas.pop_front();
      @(negedge clock);
      reset = l.rst; novaPosicao = l.nova; posicaoX = l.px; posicaoY = l.py;
      setorBloqueado = l.mask; buscaFinalizada = l.fin;
      buscaDestinoX = l.bdx; buscaDestinoY = l.bdy; destinoAceito = l.aceito;
      esp = l; espValido = 1'b1;
    end
    @(negedge clock);
    espValido = 1'b0;
    reset = 1'b0; novaPosicao = 1'b0; buscaFinalizada = 1'b0; destinoAceito = 1'b0;
  endtask

  // Per-cycle comparison against the timeline.
  always begin
    @(posedge clock);
    #1;
    if (espValido) begin
      checar("buscaReset", 32'(buscaReset), 32'(esp.eRst));
      checar("buscaNovoDado", 32'(buscaNovoDado), 32'(esp.eNd));
      checar("buscaEnable", 32'(buscaEnable), 32'(esp.eEn));
      checar("destinoValido", 32'(destinoValido), 32'(esp.eValid));
      checar("destinoX", 32'(destinoX), 32'(esp.eDx));
      checar("destinoY", 32'(destinoY), 32'(esp.eDy));
      checar("erroTimeout", 32'(erroTimeout), 32'(esp.eErro));
      checar("exploracaoCompleta", 32'(exploracaoCompleta), 32'(esp.eCompl));
      checar("ocupado", 32'(ocupado), 32'(esp.eOcup));
    end
  end

  initial begin
    logic [7:0] pX, pY, rx, ry;
    logic [3:0] m;
    int resetEm;

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checar("rst_buscaReset", 32'(buscaReset), 32'd0);
    checar("rst_buscaNovoDado", 32'(buscaNovoDado), 32'd0);
    checar("rst_buscaEnable", 32'(buscaEnable), 32'd0);
    checar("rst_destinoValido", 32'(destinoValido), 32'd0);
    checar("rst_destinoX", 32'(destinoX), 32'd0);
    checar("rst_flags", 32'({erroTimeout, exploracaoCompleta}), 32'd0);
    checar("rst_ocupado", 32'(ocupado), 32'd0);

    // Normal flow: (5,5), free sectors, done after 10 cycles with (7,3)
    gerar(8'd5, 8'd5, 4'b0000, 8'd7, 8'd3, 10, 0, 0, -1, 0);
    checar("modelo_normal_linhas", 32'(linhas.size()), 32'd15);
    checar("modelo_normal_enable", 32'(linhas[1].eEn), 32'hF);
    tocar();
    checar("normal_destinoX", 32'(destinoX), 32'd7);
    checar("normal_destinoY", 32'(destinoY), 32'd3);
    checar("normal_ocupado", 32'(ocupado), 32'd0);

    // Backpressure: accept held off for 20 cycles
    gerar(8'd5, 8'd5, 4'b0000, 8'd7, 8'd3, 3, 0, 20, -1, 0);
    checar("modelo_backpressure_linhas", 32'(linhas.size()), 32'd28);
    tocar();
    checar("backpressure_valido", 32'(destinoValido), 32'd0);

    // Retry: silent engine on both attempts
    gerar(8'd5, 8'd5, 4'b1010, 8'd7, 8'd3, 99, 99, 0, -1, 0);
    checar("modelo_retry_linhas", 32'(linhas.size()), 32'd37);
    checar("modelo_retry_enable1", 32'(linhas[1].eEn), 32'b0101);
    checar("modelo_retry_enable2", 32'(linhas[19].eEn), 32'b1111);
    tocar();
    checar("retry_erroTimeout", 32'(erroTimeout), 32'd1);
    checar("retry_ocupado", 32'(ocupado), 32'd0);

    // Exploration complete
    gerar(8'd5, 8'd5, 4'b0000, 8'd5, 8'd5, 4, 0, 0, -1, 0);
    checar("modelo_completo_linhas", 32'(linhas.size()), 32'd8);
    tocar();
    checar("completo_flag", 32'(exploracaoCompleta), 32'd1);
    checar("completo_erro_limpo", 32'(erroTimeout), 32'd0);

    // Reset in AGUARDA
    gerar(8'd20, 8'd30, 4'b0001, 8'd1, 8'd2, 10, 0, 0, 5, 2);
    tocar();
    checar("reset_meio_destinoX", 32'(destinoX), 32'd0);
    checar("reset_meio_ocupado", 32'(ocupado), 32'd0);

    // Result coincident with the timeout cycle
    gerar(8'd40, 8'd41, 4'b0011, 8'd9, 8'd2, T - 1, 0, 1, -1, 0);
    checar("modelo_coincidente_linhas", 32'(linhas.size()), 32'd21);
    tocar();
    checar("coincidente_destinoX", 32'(destinoX), 32'd9);
    checar("coincidente_erro", 32'(erroTimeout), 32'd0);

    // Random transactions
    for (int k = 0; k < 60; k++) begin
      pX = 8'($urandom); pY = 8'($urandom);
      m = ($urandom % 5 == 0) ? 4'b1111 : 4'($urandom);
      if ($urandom % 6 == 0) begin
        rx = pX; ry = pY;
      end else begin
        rx = 8'($urandom); ry = 8'($urandom);
        if (rx == pX && ry == pY) rx = rx + 8'd1;
      end
      resetEm = ($urandom % 8 == 0) ? int'($urandom_range(0, 14)) : -1;
      gerar(pX, pY, m, rx, ry, int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
            int'($urandom_range(0, 4)), resetEm, int'($urandom_range(0, 2)));
      tocar();
    end

    $display("Result: errors=%0d of %0d checks", erros, checks);
    $finish;
  end

endmodule
